// File: rtl/nibble_serial_sub_if.sv
// Operand/result bundle for the nibble-serial subtractor.
// The master drives the request and operands. The slave returns status and results.
interface nibble_serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero, ovf
    );
endinterface

// File: rtl/nibble_serial_sub.sv
// Nibble-serial subtractor: diff = a - b - bin, modulo 2^WIDTH.
// Each RUN cycle pushes one 4-bit nibble, LSB nibble first, through one
// generate/propagate lookahead slice. The slice adds a + ~b + ~bin, and the
// carry between nibbles is kept in a register. A final carry of 1 means no borrow.
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    nibble_serial_sub_if.slave  bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] a_r;         // latched minuend
    logic [WIDTH-1:0] nb_r;        // latched, inverted subtrahend
    logic             carry_r;     // carry into the current nibble
    logic [IDXW-1:0]  idx_r;       // nibble being processed
    logic [WIDTH-1:0] res_r;       // internal partial result, never exposed

    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             zero_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             accept_s;
    logic             last_s;
    logic [3:0]       p_s;
    logic [3:0]       g_s;
    logic [4:0]       c_s;
    logic [3:0]       sum_s;
    logic [WIDTH-1:0] res_nxt_s;

    // Carries c[0..4] of a 4-bit slice, all derived directly from c[0].
    function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    assign accept_s = bus.start & ((state_r == IDLE) | (state_r == DONE));
    assign last_s   = (state_r == RUN) & (idx_r == IDX_LAST);

    // Lookahead slice on the current nibble, and the result with that nibble merged in.
    always_comb begin
        p_s       = a_r[4*int'(idx_r) +: 4] ^ nb_r[4*int'(idx_r) +: 4];
        g_s       = a_r[4*int'(idx_r) +: 4] & nb_r[4*int'(idx_r) +: 4];
        c_s       = cla4(p_s, g_s, carry_r);
        sum_s     = p_s ^ c_s[3:0];
        res_nxt_s = res_r;
        res_nxt_s[4*int'(idx_r) +: 4] = sum_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. A start seen during RUN is dropped.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_nxt_s = RUN;
                else           state_nxt_s = IDLE;
            end
            RUN: begin
                if (idx_r == IDX_LAST) state_nxt_s = DONE;
                else                   state_nxt_s = RUN;
            end
            DONE: begin
                if (bus.start) state_nxt_s = RUN;
                else           state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Status decode from the upcoming state, so busy/done can be registered.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE:    begin busy_nxt_s = 1'b0; done_nxt_s = 1'b0; end
            RUN:     begin busy_nxt_s = 1'b1; done_nxt_s = 1'b0; end
            DONE:    begin busy_nxt_s = 1'b0; done_nxt_s = 1'b1; end
            default: begin busy_nxt_s = 1'b0; done_nxt_s = 1'b0; end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Operand capture on accept, and the nibble-by-nibble working state during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            nb_r    <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= IDX_ZERO;
            res_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            a_r     <= bus.a;
            nb_r    <= ~bus.b;
            carry_r <= ~bus.bin;
            idx_r   <= IDX_ZERO;
            res_r   <= {WIDTH{1'b0}};
        end else if (state_r == RUN) begin
            res_r   <= res_nxt_s;
            carry_r <= c_s[4];
            idx_r   <= idx_r + IDX_ONE;
        end else begin
            res_r   <= res_r;
            carry_r <= carry_r;
            idx_r   <= idx_r;
        end
    end

    // Results are published only on the edge that enters DONE and are held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_r <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_s) begin
            diff_r <= res_nxt_s;
            bout_r <= ~c_s[4];
            zero_r <= (res_nxt_s == {WIDTH{1'b0}});
            // Operand signs differ and the result sign differs from a. b's sign is ~nb.
            ovf_r  <= (a_r[WIDTH-1] == nb_r[WIDTH-1]) & (res_nxt_s[WIDTH-1] != a_r[WIDTH-1]);
        end else begin
            diff_r <= diff_r;
            bout_r <= bout_r;
            zero_r <= zero_r;
            ovf_r  <= ovf_r;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;
endmodule
